// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding ROM
// requests, buffers returned words with their PC in a small prefetch FIFO and
// hands them to the datapath over valid/ready. A redirect flushes the FIFO,
// discards any in-flight response and restarts fetch at the new PC.
module cpu_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_rom_req,
    output logic [15:0] o_rom_addr,
    input  logic        i_rom_ack,
    input  logic [15:0] i_rom_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [15:0] o_instr,
    output logic [15:0] o_pc,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DROP
    } state_t;

    state_t      state, state_d;
    logic [15:0] fetch_pc, fetch_pc_d;
    logic [15:0] drop_addr, drop_addr_d;

    logic [15:0] mem_pc    [DEPTH];
    logic [15:0] mem_instr [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] count, count_after, count_free;
    logic [15:0] shown_pc, shown_instr;
    logic        empty, push, pop;

    // FIFO status and handshake qualifiers
    always_comb begin
        empty         = (wr_ptr == rd_ptr);
        count         = wr_ptr - rd_ptr;
        o_instr_valid = !empty && !i_redirect;
        pop           = o_instr_valid && i_instr_ready;
        push          = (state == ST_REQ) && i_rom_ack && !i_redirect;
        count_free    = count - PW'(pop);
        count_after   = count + PW'(push) - PW'(pop);
    end

    // Head entry, or the last shown entry while the FIFO is empty
    always_comb begin
        o_pc    = shown_pc;
        o_instr = shown_instr;
        if (!empty) begin
            o_pc    = mem_pc[rd_ptr[AW-1:0]];
            o_instr = mem_instr[rd_ptr[AW-1:0]];
        end
    end

    // ROM request outputs; in DROP the address of the abandoned request is held
    always_comb begin
        o_rom_req  = (state != ST_IDLE);
        o_rom_addr = (state == ST_DROP) ? drop_addr : fetch_pc;
    end

    // Fetch FSM next state, fetch PC and dropped-request address
    always_comb begin
        state_d     = state;
        fetch_pc_d  = fetch_pc;
        drop_addr_d = drop_addr;
        case (state)
            ST_IDLE: begin
                if (i_redirect) begin
                    fetch_pc_d = i_redirect_pc;
                    state_d    = ST_REQ;
                end else if (count_free < DEPTH_P) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_redirect) begin
                    fetch_pc_d = i_redirect_pc;
                    if (!i_rom_ack) begin
                        state_d     = ST_DROP;
                        drop_addr_d = fetch_pc;
                    end
                end else if (i_rom_ack) begin
                    fetch_pc_d = fetch_pc + 16'd1;
                    state_d    = (count_after < DEPTH_P) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (i_redirect) begin
                    fetch_pc_d = i_redirect_pc;
                end
                if (i_rom_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, fetch PC and dropped-request address registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state     <= state_d;
            fetch_pc  <= fetch_pc_d;
            drop_addr <= drop_addr_d;
        end
    end

    // Prefetch FIFO storage and pointers; a redirect empties it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_pc      <= '{default: '0};
            mem_instr   <= '{default: '0};
            shown_pc    <= '0;
            shown_instr <= '0;
        end else begin
            shown_pc    <= o_pc;
            shown_instr <= o_instr;
            if (i_redirect) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) begin
                    mem_pc[wr_ptr[AW-1:0]]    <= o_rom_addr;
                    mem_instr[wr_ptr[AW-1:0]] <= i_rom_data;
                    wr_ptr                    <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit with a ROM model of configurable ack latency
// returning data = addr ^ 16'hA5A5.
module tb_cpu_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int wait_cnt;

    cpu_fetch_unit #(
        .RESET_PC(16'h0010),
        .DEPTH(2)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .o_rom_req(rom_req),
        .o_rom_addr(rom_addr),
        .i_rom_ack(rom_ack),
        .i_rom_data(rom_data),
        .o_instr_valid(instr_valid),
        .i_instr_ready(instr_ready),
        .o_instr(instr),
        .o_pc(pc),
        .i_redirect(redirect),
        .i_redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: acks in the lat-th cycle of a request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (!rom_req || rom_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end
    assign rom_ack  = rom_req && (wait_cnt >= lat - 1);
    assign rom_data = rom_addr ^ 16'hA5A5;

    task automatic test_reset();
        @(negedge clk);
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", rom_req); end
        checks++; if (rom_addr !== 16'h0010) begin errors++; $display("FAIL reset_addr got %h want 0010", rom_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", instr); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", pc); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rom_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", rom_req); end
        checks++; if (rom_addr !== 16'h0010) begin errors++; $display("FAIL first_addr got %h want 0010", rom_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL first_valid_early got %b want 0", instr_valid); end
    endtask

    task automatic test_stream();
        logic [15:0] exp;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp = 16'h0010 + 16'(i);
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, instr_valid); end
            checks++; if (pc !== exp) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, pc, exp); end
            checks++; if (instr !== (exp ^ 16'hA5A5)) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, instr, exp ^ 16'hA5A5); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp;
        rst_n = 1'b0; instr_ready = 1'b0; lat = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL bp_req_off[%0d] got %b want 0", i, rom_req); end
            checks++; if (pc !== 16'h0010 || instr_valid !== 1'b1) begin errors++; $display("FAIL bp_head[%0d] got pc %h v %b want 0010 v 1", i, pc, instr_valid); end
        end
        instr_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            exp = 16'h0010 + 16'(i);
            checks++; if (instr_valid !== 1'b1 || pc !== exp) begin errors++; $display("FAIL bp_drain[%0d] got pc %h v %b want %h v 1", i, pc, instr_valid, exp); end
        end
    endtask

    task automatic test_redirect_drop();
        bit seen;
        rst_n = 1'b0; lat = 3; instr_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; redirect = 1'b1; redirect_pc = 16'h0005;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0005) begin errors++; $display("FAIL drop_req0005 got %b/%h want 1/0005", rom_req, rom_addr); end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0005) begin errors++; $display("FAIL drop_hold got %b/%h want 1/0005", rom_req, rom_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b want 0", instr_valid); end
        @(negedge clk);
        checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0200) begin errors++; $display("FAIL drop_newreq got %b/%h want 1/0200", rom_req, rom_addr); end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL drop_timeout got no valid want valid within 20 cycles"); end
        else if (pc !== 16'h0200 || instr !== (16'h0200 ^ 16'hA5A5)) begin
            errors++; $display("FAIL drop_first got %h/%h want 0200/%h", pc, instr, 16'h0200 ^ 16'hA5A5);
        end
    endtask

    task automatic test_redirect_ack_pop();
        lat = 1;
        repeat (3) @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || rom_req !== 1'b1) begin errors++; $display("FAIL rap_steady got v %b req %b want 1 1", instr_valid, rom_req); end
        redirect = 1'b1; redirect_pc = 16'h0300;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rap_force got %b want 0", instr_valid); end
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rap_empty got %b want 0", instr_valid); end
        checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0300) begin errors++; $display("FAIL rap_req got %b/%h want 1/0300", rom_req, rom_addr); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || pc !== 16'h0300) begin errors++; $display("FAIL rap_first got v %b pc %h want 1 0300", instr_valid, pc); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || pc !== 16'h0301) begin errors++; $display("FAIL rap_second got v %b pc %h want 1 0301", instr_valid, pc); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp;
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_gap got %b want 0", instr_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = 16'hFFFE + 16'(i);
            checks++; if (instr_valid !== 1'b1 || pc !== exp) begin errors++; $display("FAIL wrap_pc[%0d] got v %b pc %h want 1 %h", i, instr_valid, pc, exp); end
        end
    endtask

    task automatic test_reset_drop();
        @(negedge clk);
        checks++; if (pc !== 16'h0002 || rom_addr !== 16'h0003) begin errors++; $display("FAIL rd_pre got pc %h addr %h want 0002 0003", pc, rom_addr); end
        lat = 6; redirect = 1'b1; redirect_pc = 16'h0400;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0003) begin errors++; $display("FAIL rd_drop got %b/%h want 1/0003", rom_req, rom_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rom_req !== 1'b0 || rom_addr !== 16'h0010) begin errors++; $display("FAIL rd_async_rom got %b/%h want 0/0010", rom_req, rom_addr); end
        checks++; if (instr_valid !== 1'b0 || pc !== 16'h0000 || instr !== 16'h0000) begin errors++; $display("FAIL rd_async_out got %b/%h/%h want 0/0000/0000", instr_valid, pc, instr); end
        @(negedge clk);
        rst_n = 1'b1; lat = 1;
        @(negedge clk);
        checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0010) begin errors++; $display("FAIL rd_restart got %b/%h want 1/0010", rom_req, rom_addr); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || pc !== 16'h0010) begin errors++; $display("FAIL rd_first got v %b pc %h want 1 0010", instr_valid, pc); end
    endtask

    task automatic test_reset_full();
        instr_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || rom_req !== 1'b0) begin errors++; $display("FAIL rf_full got v %b req %b want 1 0", instr_valid, rom_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || pc !== 16'h0000 || instr !== 16'h0000 || rom_req !== 1'b0) begin
            errors++; $display("FAIL rf_async got v %b pc %h instr %h req %b want 0 0000 0000 0", instr_valid, pc, instr, rom_req);
        end
        @(negedge clk);
        rst_n = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || pc !== 16'h0010) begin errors++; $display("FAIL rf_restart got v %b pc %h want 1 0010", instr_valid, pc); end
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_drop();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
